song_note_sequencer: RTL and testbench

Upstream sample source for the audio PWM generator. Walks a song stored in an external note ROM, one 12-bit note word per address, and synthesises an 8-bit square-wave sample stream at a fixed sample rate. Its `music_data` output drives the PWM generator's 8-bit sample input directly. A play/stop control interface and busy/done status let the alarm controller start the song, abort it, and detect its end.

---
 rtl/song_note_sequencer.sv | 145 ++++++++++++++
 tb/tb_song_note_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/song_note_sequencer.sv
// Square-wave song sequencer: walks a registered note ROM and emits one 8-bit
// sample per sample period, with play/stop control and busy/done status.
module song_note_sequencer #(
  parameter int SAMPLE_DIV  = 12500,
  parameter int DUR_SAMPLES = 800,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic [6:0]        volume,
  output logic [ADDR_W-1:0] note_addr,
  input  logic [11:0]       note_data,
  output logic [7:0]        music_data,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W    = $clog2(SAMPLE_DIV);
  localparam int DUR_BITS = $clog2(15 * DUR_SAMPLES + 1);
  localparam int DUR_W    = (DUR_BITS > 14) ? DUR_BITS : 14;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE} state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [7:0]        half_per;
  logic [7:0]        ph_cnt;
  logic              phase;
  logic [DUR_W-1:0]  dur_cnt;
  logic              note_end;
  logic              last_addr;

  // Midscale +/- volume, clamped to the 8-bit sample range; a zero
  // half-period is a rest and stays at midscale.
  function automatic logic [7:0] square_sample(input logic [7:0] hp,
                                               input logic       ph,
                                               input logic [6:0] vol);
    logic signed [9:0] mid;
    logic signed [9:0] amp;
    logic signed [9:0] s;
    mid = 10'sd128;
    amp = signed'({3'b000, vol});
    if (hp == 8'd0)
      s = mid;
    else if (ph)
      s = mid + amp;
    else
      s = mid - amp;
    if (s > 10'sd255)
      s = 10'sd255;
    else if (s < 10'sd0)
      s = 10'sd0;
    return s[7:0];
  endfunction

  assign tick      = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign note_end  = tick && (dur_cnt == DUR_W'(1));
  assign last_addr = (note_addr == {ADDR_W{1'b1}});
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (play && !stop) state_next = FETCH;
      FETCH: state_next = LOAD;
      LOAD:  state_next = (note_data[11:8] == 4'd0) ? DONE : PLAY;
      PLAY:  if (note_end) state_next = last_addr ? DONE : FETCH;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (stop && state != IDLE)
      state_next = IDLE;
  end

  // Note datapath: load on LOAD, advance phase/duration on each PLAY tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      note_addr    <= '0;
      half_per     <= '0;
      ph_cnt       <= '0;
      phase        <= 1'b0;
      dur_cnt      <= '0;
      music_data   <= 8'd128;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (stop && state != IDLE) begin
        music_data <= 8'd128;
      end else begin
        case (state)
          IDLE: begin
            music_data <= 8'd128;
            if (play && !stop)
              note_addr <= '0;
          end
          LOAD: begin
            if (note_data[11:8] != 4'd0) begin
              half_per <= note_data[7:0];
              dur_cnt  <= DUR_W'(note_data[11:8]) * DUR_W'(DUR_SAMPLES);
              ph_cnt   <= '0;
              phase    <= 1'b1;
            end
          end
          PLAY: begin
            if (tick) begin
              music_data   <= square_sample(half_per, phase, volume);
              sample_valid <= 1'b1;
              if (ph_cnt + 8'd1 == half_per) begin
                ph_cnt <= '0;
                phase  <= ~phase;
              end else begin
                ph_cnt <= ph_cnt + 8'd1;
              end
              dur_cnt <= dur_cnt - 1'b1;
              if (note_end && !last_addr)
                note_addr <= note_addr + 1'b1;
            end
          end
          DONE: music_data <= 8'd128;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_note_sequencer.sv
// Randomized bench for song_note_sequencer: a short-period instance for song
// behaviour and control conflicts, and a long-duration instance for d=15.
module tb_song_note_sequencer;

  logic        clk = 1'b0;
  logic        reset, play, stop;
  logic [6:0]  volume;
  logic [2:0]  note_addr;
  logic [11:0] note_data;
  logic [7:0]  music_data;
  logic        sample_valid, busy, done;
  logic [11:0] rom [8];

  logic        play_l, stop_l;
  logic [6:0]  volume_l;
  logic [2:0]  note_addr_l;
  logic [11:0] note_data_l;
  logic [7:0]  music_data_l;
  logic        sample_valid_l, busy_l, done_l;
  logic [11:0] rom_l [8];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  song_note_sequencer #(.SAMPLE_DIV(4), .DUR_SAMPLES(4), .ADDR_W(3)) u_dut (
    .clk(clk), .reset(reset), .play(play), .stop(stop), .volume(volume),
    .note_addr(note_addr), .note_data(note_data), .music_data(music_data),
    .sample_valid(sample_valid), .busy(busy), .done(done));

  song_note_sequencer #(.SAMPLE_DIV(4), .DUR_SAMPLES(800), .ADDR_W(3)) u_long (
    .clk(clk), .reset(reset), .play(play_l), .stop(stop_l), .volume(volume_l),
    .note_addr(note_addr_l), .note_data(note_data_l), .music_data(music_data_l),
    .sample_valid(sample_valid_l), .busy(busy_l), .done(done_l));

  always_ff @(posedge clk) begin
    note_data   <= rom[note_addr];
    note_data_l <= rom_l[note_addr_l];
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sample k of a note with half-period hp is high while (k/hp) is even.
  task automatic run_song(input string tag, input int vol, input bit hold_play);
    int exp_q[$];
    int got_q[$];
    int exp_last, ndone, hold_viol, prev, d, hp;
    bit fin;
    exp_last = 7;
    for (int a = 0; a < 8; a++) begin
      d  = int'(rom[a][11:8]);
      hp = int'(rom[a][7:0]);
      if (d == 0) begin
        exp_last = a;
        break;
      end
      for (int k = 0; k < d * 4; k++) begin
        if (hp == 0) exp_q.push_back(128);
        else exp_q.push_back(((k / hp) % 2 == 0) ? 128 + vol : 128 - vol);
      end
    end
    ndone = 0; hold_viol = 0; prev = 128; fin = 1'b0;
    volume = 7'(vol);
    play = 1'b1;
    step();
    check({tag, ".busy_rise"}, 32'(busy), 1);
    if (!hold_play) play = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      step();
      if (sample_valid) begin
        got_q.push_back(32'(music_data));
        prev = 32'(music_data);
      end else if (32'(music_data) != prev) begin
        hold_viol++;
      end
      if (done) begin
        ndone++;
        play = 1'b0;
        check({tag, ".busy_at_done"}, 32'(busy), 1);
        step();
        check({tag, ".busy_after_done"}, 32'(busy), 0);
        check({tag, ".silence_after_done"}, 32'(music_data), 128);
        check({tag, ".done_width"}, 32'(done), 0);
        fin = 1'b1;
        break;
      end
    end
    play = 1'b0;
    if (!fin) check({tag, ".timeout"}, 1, 0);
    check({tag, ".nsamples"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] != exp_q[i]) begin
        check($sformatf("%s.sample%0d", tag, i), got_q[i], exp_q[i]);
        break;
      end
    end
    check({tag, ".hold"}, hold_viol, 0);
    check({tag, ".ndone"}, ndone, 1);
    check({tag, ".last_addr"}, 32'(note_addr), exp_last);
  endtask

  task automatic wait_samples(input string tag, input int n);
    int seen;
    seen = 0;
    for (int cyc = 0; cyc < 500 && seen < n; cyc++) begin
      step();
      if (sample_valid) seen++;
    end
    if (seen < n) check({tag, ".timeout"}, seen, n);
  endtask

  initial begin
    int cnt, bad, nd, exp_s;
    bit fin;
    reset = 1'b1; play = 1'b0; stop = 1'b0; volume = '0;
    play_l = 1'b0; stop_l = 1'b0; volume_l = '0;
    for (int i = 0; i < 8; i++) begin
      rom[i] = '0;
      rom_l[i] = '0;
    end
    step(); step();
    check("rst.music", 32'(music_data), 128);
    check("rst.addr", 32'(note_addr), 0);
    check("rst.valid", 32'(sample_valid), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    reset = 1'b0;
    step();

    // Tone then end
    rom[0] = 12'h102;
    run_song("tone", 100, 1'b0);

    // Rest note
    rom[0] = 12'h200;
    run_song("rest", 55, 1'b0);

    // Volume extremes
    rom[0] = 12'h103; rom[1] = 12'h000;
    run_song("vol127", 127, 1'b0);
    run_song("vol0", 0, 1'b0);

    // Address wrap: all 8 notes present
    for (int i = 0; i < 8; i++) rom[i] = 12'h101;
    run_song("wrap", 77, 1'b0);
    for (int i = 0; i < 6; i++) step();
    check("wrap.no_refetch", 32'(note_addr), 7);
    check("wrap.idle", 32'(busy), 0);

    // Play held high during the song: no restart
    rom[0] = 12'h203; rom[1] = 12'h102; rom[2] = 12'h000;
    run_song("hold_play", 40, 1'b1);

    // Randomized songs
    for (int it = 0; it < 6; it++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int a = 0; a < 8; a++)
        rom[a] = (a < len) ? {4'($urandom_range(1, 3)), 8'($urandom_range(0, 4))} : 12'h000;
      run_song($sformatf("rand%0d", it), $urandom_range(0, 127), 1'b0);
    end

    // Stop mid-note
    rom[0] = 12'hF01; rom[1] = 12'h000;
    volume = 7'd50;
    play = 1'b1; step(); play = 1'b0;
    wait_samples("stop", 3);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop.busy", 32'(busy), 0);
    check("stop.music", 32'(music_data), 128);
    check("stop.valid", 32'(sample_valid), 0);
    check("stop.done", 32'(done), 0);
    check("stop.addr", 32'(note_addr), 0);
    cnt = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sample_valid) cnt++;
      if (done) nd++;
    end
    check("stop.quiet_valid", cnt, 0);
    check("stop.quiet_done", nd, 0);

    // play and stop together in IDLE
    play = 1'b1; stop = 1'b1;
    step(); step(); step();
    check("conflict.busy", 32'(busy), 0);
    check("conflict.music", 32'(music_data), 128);
    play = 1'b0; stop = 1'b0;
    step();

    // Reset mid-PLAY
    rom[0] = 12'h301; rom[1] = 12'h102; rom[2] = 12'h000;
    play = 1'b1; step(); play = 1'b0;
    wait_samples("midrst", 14);
    reset = 1'b1; step();
    check("midrst.music", 32'(music_data), 128);
    check("midrst.addr", 32'(note_addr), 0);
    check("midrst.valid", 32'(sample_valid), 0);
    check("midrst.busy", 32'(busy), 0);
    check("midrst.done", 32'(done), 0);
    reset = 1'b0; step();

    // Long duration: d=15 at 800 samples per unit
    rom_l[0] = 12'hF01; rom_l[1] = 12'h000;
    volume_l = 7'd127;
    play_l = 1'b1; step(); play_l = 1'b0;
    cnt = 0; bad = 0; nd = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      step();
      if (sample_valid_l) begin
        exp_s = (cnt % 2 == 0) ? 255 : 1;
        if (32'(music_data_l) != exp_s) bad++;
        cnt++;
      end
      if (done_l) begin
        nd++;
        fin = 1'b1;
        break;
      end
    end
    if (!fin) check("long.timeout", 1, 0);
    check("long.nsamples", cnt, 12000);
    check("long.bad_samples", bad, 0);
    check("long.ndone", nd, 1);
    step();
    check("long.silence", 32'(music_data_l), 128);
    check("long.busy", 32'(busy_l), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
